// File: rtl/matrix_mac_calculator.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_mac_calculator
//  Description : Sequential N x N matrix engine. Computes A*B with a single
//                multiply-accumulate datapath, or element-wise A+B, behind a
//                start/done handshake. Results are truncated to W bits, and
//                overflow is flagged.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_mac_calculator #(
    parameter int N = 3,
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [N*N*W-1:0] A,
    input  logic [N*N*W-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [N*N*W-1:0] Result
);

    localparam int c_NN = N * N;
    localparam int c_IW = $clog2(N);
    localparam int c_EW = $clog2(N * N);
    localparam int c_AW = 2 * W + $clog2(N);

    localparam logic [c_IW-1:0] c_ONE  = c_IW'(1);
    localparam logic [c_IW-1:0] c_LAST = c_IW'(N - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_COMPUTE = 2'd1;
    localparam logic [1:0] c_FINISH  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [N*N*W-1:0] r_a;
    logic [N*N*W-1:0] r_b;
    logic             r_mode;
    logic [c_IW-1:0]  r_i;
    logic [c_IW-1:0]  r_j;
    logic [c_IW-1:0]  r_k;
    logic [c_AW-1:0]  r_acc;
    logic             r_ovf_acc;
    logic             r_done;
    logic             r_overflow;
    logic [W-1:0]     r_buf    [c_NN];
    logic [W-1:0]     r_result [c_NN];

    logic [W-1:0]     w_a_el [c_NN];
    logic [W-1:0]     w_b_el [c_NN];
    logic [c_EW-1:0]  w_idx_ij;
    logic [c_EW-1:0]  w_idx_ik;
    logic [c_EW-1:0]  w_idx_kj;
    logic [2*W-1:0]   w_prod;
    logic [c_AW-1:0]  w_acc_sum;
    logic [W:0]       w_add;
    logic             w_i_last;
    logic             w_j_last;
    logic             w_k_last;
    logic             w_last;

    // Element (0,0) sits at the MSB of every flat bus
    for (genvar e = 0; e < c_NN; e++) begin : g_elem
        assign w_a_el[e] = r_a[(c_NN-e)*W-1 -: W];
        assign w_b_el[e] = r_b[(c_NN-e)*W-1 -: W];
        assign Result[(c_NN-e)*W-1 -: W] = r_result[e];
    end

    assign w_idx_ij  = c_EW'(r_i) * c_EW'(N) + c_EW'(r_j);
    assign w_idx_ik  = c_EW'(r_i) * c_EW'(N) + c_EW'(r_k);
    assign w_idx_kj  = c_EW'(r_k) * c_EW'(N) + c_EW'(r_j);
    assign w_prod    = (2*W)'(w_a_el[w_idx_ik]) * (2*W)'(w_b_el[w_idx_kj]);
    assign w_acc_sum = r_acc + c_AW'(w_prod);
    assign w_add     = {1'b0, w_a_el[w_idx_ij]} + {1'b0, w_b_el[w_idx_ij]};

    assign w_i_last = (r_i == c_LAST);
    assign w_j_last = (r_j == c_LAST);
    assign w_k_last = (r_k == c_LAST);
    assign w_last   = r_mode ? (w_i_last & w_j_last) : (w_i_last & w_j_last & w_k_last);

    assign busy     = (r_state != c_IDLE);
    assign done     = r_done;
    assign overflow = r_overflow;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state: accept in IDLE, leave COMPUTE on the last element, FINISH lasts one cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:    if (start)  w_state_nxt = c_COMPUTE;
            c_COMPUTE: if (w_last) w_state_nxt = c_FINISH;
            c_FINISH:  w_state_nxt = c_IDLE;
            default:   w_state_nxt = c_IDLE;
        endcase
    end

    // Operand capture, index walk, accumulation and result publication
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_mode     <= 1'b0;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_acc      <= '0;
            r_ovf_acc  <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            for (int x = 0; x < c_NN; x++) begin
                r_buf[x]    <= '0;
                r_result[x] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_a       <= A;
                        r_b       <= B;
                        r_mode    <= mode;
                        r_i       <= '0;
                        r_j       <= '0;
                        r_k       <= '0;
                        r_acc     <= '0;
                        r_ovf_acc <= 1'b0;
                    end
                end
                c_COMPUTE: begin
                    if (r_mode || w_k_last) begin
                        // One output element completes this cycle; step to the next (i,j)
                        if (r_mode) begin
                            r_buf[w_idx_ij] <= w_add[W-1:0];
                            r_ovf_acc       <= r_ovf_acc | w_add[W];
                        end else begin
                            r_buf[w_idx_ij] <= w_acc_sum[W-1:0];
                            r_ovf_acc       <= r_ovf_acc | (|w_acc_sum[c_AW-1:W]);
                            r_acc           <= '0;
                            r_k             <= '0;
                        end
                        if (w_j_last) begin
                            r_j <= '0;
                            r_i <= w_i_last ? '0 : r_i + c_ONE;
                        end else begin
                            r_j <= r_j + c_ONE;
                        end
                    end else begin
                        r_acc <= w_acc_sum;
                        r_k   <= r_k + c_ONE;
                    end
                end
                c_FINISH: begin
                    r_result   <= r_buf;
                    r_overflow <= r_ovf_acc;
                    r_done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_mac_calculator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_mac_calculator
//  Description : Self-checking bench for matrix_mac_calculator (N=3/W=16 and
//                N=4/W=8 instances) against a plain-arithmetic matrix model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_mac_calculator;

    typedef longint unsigned elems_t [16];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         start3, mode3, busy3, done3, ovf3;
    logic [143:0] a3, b3, res3;
    logic         start4, mode4, busy4, done4, ovf4;
    logic [127:0] a4, b4, res4;

    int checks   = 0;
    int failures = 0;

    matrix_mac_calculator #(.N(3), .W(16)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .mode(mode3), .A(a3), .B(b3),
        .busy(busy3), .done(done3), .overflow(ovf3), .Result(res3)
    );

    matrix_mac_calculator #(.N(4), .W(8)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .overflow(ovf4), .Result(res4)
    );

    // Exact matrix arithmetic, then truncation to w bits
    function automatic void ref_model(input int n, input int w, input bit m,
                                      input elems_t a, input elems_t b,
                                      output elems_t r, output bit ovf);
        longint unsigned s;
        ovf = 1'b0;
        for (int x = 0; x < 16; x++) r[x] = 0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 0;
                if (m) s = a[i*n+j] + b[i*n+j];
                else for (int k = 0; k < n; k++) s += a[i*n+k] * b[k*n+j];
                if (s >= (64'd1 << w)) ovf = 1'b1;
                r[i*n+j] = s & ((64'd1 << w) - 1);
            end
        end
    endfunction

    function automatic logic [143:0] pack3(input elems_t x);
        logic [143:0] p = '0;
        for (int e = 0; e < 9; e++) p[(9-e)*16-1 -: 16] = x[e][15:0];
        return p;
    endfunction

    function automatic logic [127:0] pack4(input elems_t x);
        logic [127:0] p = '0;
        for (int e = 0; e < 16; e++) p[(16-e)*8-1 -: 8] = x[e][7:0];
        return p;
    endfunction

    // Random elements, biased towards all-ones so overflow is exercised
    task automatic rand_elems(input int w, output elems_t x);
        for (int e = 0; e < 16; e++) begin
            if ($urandom_range(0, 3) == 0) x[e] = (64'd1 << w) - 1;
            else                           x[e] = $urandom_range(0, (1 << w) - 1);
        end
    endtask

    task automatic run3(input string name, input bit m, input elems_t ea, input elems_t eb);
        elems_t er;
        bit     eovf;
        int     cyc;
        int     lat;
        ref_model(3, 16, m, ea, eb, er, eovf);
        lat = m ? 10 : 28;
        @(negedge clk);
        a3 = pack3(ea); b3 = pack3(eb); mode3 = m; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        checks++;
        if (busy3 !== 1'b1) begin
            failures++; $display("FAIL %s busy_after_accept got=%b want=1", name, busy3);
        end
        a3 = ~a3; b3 = ~b3; mode3 = ~m;
        cyc = 0;
        while (done3 !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        checks++;
        if (cyc !== lat) begin
            failures++; $display("FAIL %s latency got=%0d want=%0d", name, cyc, lat);
        end
        checks++;
        if (res3 !== pack3(er)) begin
            failures++; $display("FAIL %s result got=%h want=%h", name, res3, pack3(er));
        end
        checks++;
        if (ovf3 !== eovf) begin
            failures++; $display("FAIL %s overflow got=%b want=%b", name, ovf3, eovf);
        end
        checks++;
        if (busy3 !== 1'b0) begin
            failures++; $display("FAIL %s busy_at_done got=%b want=0", name, busy3);
        end
        @(posedge clk); #1;
        checks++;
        if (done3 !== 1'b0 || res3 !== pack3(er)) begin
            failures++; $display("FAIL %s done_pulse/hold done=%b res=%h want done=0 res=%h", name, done3, res3, pack3(er));
        end
    endtask

    task automatic run4(input string name, input bit m, input elems_t ea, input elems_t eb);
        elems_t er;
        bit     eovf;
        int     cyc;
        int     lat;
        ref_model(4, 8, m, ea, eb, er, eovf);
        lat = m ? 17 : 65;
        @(negedge clk);
        a4 = pack4(ea); b4 = pack4(eb); mode4 = m; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        a4 = ~a4; b4 = ~b4; mode4 = ~m;
        cyc = 0;
        while (done4 !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        checks++;
        if (cyc !== lat) begin
            failures++; $display("FAIL %s latency got=%0d want=%0d", name, cyc, lat);
        end
        checks++;
        if (res4 !== pack4(er) || ovf4 !== eovf) begin
            failures++; $display("FAIL %s result got=%h ovf=%b want=%h ovf=%b", name, res4, ovf4, pack4(er), eovf);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            checks++;
            if ({busy3, done3, ovf3, res3} !== '0) begin
                failures++; $display("FAIL reset_idle cycle=%0d busy=%b done=%b ovf=%b res=%h want all 0", c, busy3, done3, ovf3, res3);
            end
        end
        checks++;
        if ({busy4, done4, ovf4, res4} !== '0) begin
            failures++; $display("FAIL reset_idle_n4 busy=%b done=%b ovf=%b res=%h want all 0", busy4, done4, ovf4, res4);
        end
    endtask

    task automatic test_product();
        elems_t ea = '{1,2,3,4,5,6,7,8,9,0,0,0,0,0,0,0};
        elems_t eb = '{7,3,5,12,11,17,20,3,0,0,0,0,0,0,0,0};
        run3("product", 1'b0, ea, eb);
    endtask

    task automatic test_sum();
        elems_t ea = '{1,2,3,4,5,6,7,8,9,0,0,0,0,0,0,0};
        elems_t eb = '{7,3,5,12,11,17,20,3,0,0,0,0,0,0,0,0};
        run3("sum", 1'b1, ea, eb);
    endtask

    task automatic test_overflow();
        elems_t ea, eb, eid, eone;
        for (int e = 0; e < 16; e++) begin
            ea[e] = 64'hFFFF; eb[e] = 2; eone[e] = 1;
            eid[e] = (e < 9 && (e % 4) == 0) ? 1 : 0;
        end
        run3("ovf_prod_x2", 1'b0, ea, eb);
        run3("ovf_identity", 1'b0, ea, eid);
        run3("ovf_sum_plus1", 1'b1, ea, eone);
    endtask

    // start held high with operands changing every cycle
    task automatic test_back_to_back();
        elems_t       ea, eb, er;
        bit           eovf;
        bit           exp_done;
        logic [143:0] q_res[$];
        bit           q_ovf[$];
        int           next_accept = 1;
        @(negedge clk);
        mode3 = 1'b0; start3 = 1'b1;
        for (int edge_n = 1; edge_n <= 87; edge_n++) begin
            rand_elems(16, ea); rand_elems(16, eb);
            a3 = pack3(ea); b3 = pack3(eb);
            if (edge_n == next_accept) begin
                ref_model(3, 16, 1'b0, ea, eb, er, eovf);
                q_res.push_back(pack3(er)); q_ovf.push_back(eovf);
                next_accept += 29;
            end
            @(posedge clk); #1;
            exp_done = (edge_n % 29 == 0);
            checks++;
            if (done3 !== exp_done || busy3 !== !exp_done) begin
                failures++; $display("FAIL b2b_handshake edge=%0d done=%b busy=%b want done=%b busy=%b", edge_n, done3, busy3, exp_done, !exp_done);
            end
            if (exp_done && q_res.size() > 0) begin
                checks++;
                if (res3 !== q_res[0] || ovf3 !== q_ovf[0]) begin
                    failures++; $display("FAIL b2b_result edge=%0d got=%h ovf=%b want=%h ovf=%b", edge_n, res3, ovf3, q_res[0], q_ovf[0]);
                end
                void'(q_res.pop_front()); void'(q_ovf.pop_front());
            end
            @(negedge clk);
        end
        start3 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        elems_t ea, eb;
        bit     seen;
        rand_elems(16, ea); rand_elems(16, eb);
        @(negedge clk);
        a3 = pack3(ea); b3 = pack3(eb); mode3 = 1'b0; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        repeat (12) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy3, done3, ovf3, res3} !== '0) begin
            failures++; $display("FAIL reset_mid_clear busy=%b done=%b ovf=%b res=%h want all 0", busy3, done3, ovf3, res3);
        end
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done3 === 1'b1 || busy3 === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL reset_mid_no_done got=%b want=0", seen);
        end
        rand_elems(16, ea); rand_elems(16, eb);
        run3("after_reset_prod", 1'b0, ea, eb);
    endtask

    task automatic test_n4_random();
        elems_t ea, eb;
        for (int t = 0; t < 6; t++) begin
            rand_elems(8, ea); rand_elems(8, eb);
            run4($sformatf("n4_rand%0d", t), t[0], ea, eb);
        end
        rand_elems(8, ea); rand_elems(8, eb);
        @(negedge clk);
        a4 = pack4(ea); b4 = pack4(eb); mode4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (12) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy4, done4, ovf4, res4} !== '0) begin
            failures++; $display("FAIL n4_reset_mid busy=%b done=%b ovf=%b res=%h want all 0", busy4, done4, ovf4, res4);
        end
        @(negedge clk); rst = 1'b0;
        rand_elems(8, ea); rand_elems(8, eb);
        run4("n4_after_reset", 1'b0, ea, eb);
        rand_elems(8, ea); rand_elems(8, eb);
        run4("n4_after_reset_sum", 1'b1, ea, eb);
    endtask

    initial begin
        rst = 1'b1;
        start3 = 1'b0; mode3 = 1'b0; a3 = '0; b3 = '0;
        start4 = 1'b0; mode4 = 1'b0; a4 = '0; b4 = '0;
        test_reset();
        test_product();
        test_sum();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_n4_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
